victim_cache_ctrl: RTL and testbench

//   Sequencing controller for the 8-way fully-associative victim cache. Holds the tag/valid

---
 rtl/victim_cache_ctrl_if.sv | 35 +++
 rtl/victim_cache_ctrl.sv | 165 ++++++++++++++++
 tb/tb_victim_cache_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/victim_cache_ctrl_if.sv
// Request, response, data-array and LRU-tracker signals of the victim cache controller.
// The master side is the L1 miss path plus LRU tracker environment; the slave side is
// the controller itself.
interface victim_cache_ctrl_if #(
    parameter int TAG_W = 26
);
    logic             lookup_valid;
    logic [TAG_W-1:0] lookup_tag;
    logic             lookup_ready;
    logic             evict_valid;
    logic [TAG_W-1:0] evict_tag;
    logic             evict_ready;
    logic             resp_valid;
    logic             resp_hit;
    logic [2:0]       resp_way;
    logic             wr_en;
    logic [2:0]       wr_way;
    logic [7:0]       lru_number;
    logic [7:0]       lru_update;
    logic             add_cache;
    logic             lru_clr;
    logic             busy;

    modport master (
        output lookup_valid, lookup_tag, evict_valid, evict_tag, lru_number,
        input  lookup_ready, evict_ready, resp_valid, resp_hit, resp_way,
        input  wr_en, wr_way, lru_update, add_cache, lru_clr, busy
    );

    modport slave (
        input  lookup_valid, lookup_tag, evict_valid, evict_tag, lru_number,
        output lookup_ready, evict_ready, resp_valid, resp_hit, resp_way,
        output wr_en, wr_way, lru_update, add_cache, lru_clr, busy
    );
endinterface

// File: rtl/victim_cache_ctrl.sv
// Sequencing controller for an 8-way fully-associative victim cache.
// Owns the tag/valid array, answers L1-miss lookups (a hit hands the line back to L1 and
// frees the way), inserts L1 victims, and issues one-cycle pulses to the LRU tracker.
module victim_cache_ctrl #(
    parameter int TAG_W = 26
) (
    input  logic                clk,
    input  logic                reset,
    victim_cache_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        L_CMP = 3'd1,
        L_RSP = 3'd2,
        I_CMP = 3'd3,
        I_WR  = 3'd4
    } state_t;

    state_t           state;
    logic [7:0]       valid;
    logic [TAG_W-1:0] tags [8];
    logic [TAG_W-1:0] req_tag;
    logic             dup_hit;

    logic             resp_valid_q;
    logic             resp_hit_q;
    logic [2:0]       resp_way_q;
    logic             wr_en_q;
    logic [2:0]       wr_way_q;
    logic [7:0]       lru_update_q;
    logic             add_cache_q;

    logic [7:0]       evict_match;
    logic [7:0]       cmp_match;
    logic [7:0]       free_ways;
    logic             victim_free;
    logic [2:0]       victim_way;

    // Index of the lowest set bit, 0 when the vector is empty.
    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic [7:0] one_hot(input logic [2:0] w);
        return 8'b1 << w;
    endfunction

    // Associative match of the incoming victim tag and of the registered request tag.
    always_comb begin
        evict_match = '0;
        cmp_match   = '0;
        for (int i = 0; i < 8; i++) begin
            evict_match[i] = valid[i] && (tags[i] == bus.evict_tag);
            cmp_match[i]   = valid[i] && (tags[i] == req_tag);
        end
    end

    // Insert target: a free way first, otherwise the way the LRU tracker marks as oldest.
    always_comb begin
        free_ways   = ~valid;
        victim_free = |free_ways;
        if (victim_free) begin
            victim_way = lowest_idx(free_ways);
        end else begin
            victim_way = lowest_idx(bus.lru_number);
        end
    end

    // Main FSM; pulse outputs are registered and default to zero every cycle.
    // The duplicate check for an insert is taken at acceptance so its LRU pulse
    // is already visible during I_CMP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            valid        <= '0;
            for (int i = 0; i < 8; i++) tags[i] <= '0;
            req_tag      <= '0;
            dup_hit      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_way_q   <= '0;
            wr_en_q      <= 1'b0;
            wr_way_q     <= '0;
            lru_update_q <= '0;
            add_cache_q  <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_way_q   <= '0;
            wr_en_q      <= 1'b0;
            wr_way_q     <= '0;
            lru_update_q <= '0;
            add_cache_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.lookup_valid) begin
                        req_tag <= bus.lookup_tag;
                        state   <= L_CMP;
                    end else if (bus.evict_valid) begin
                        req_tag <= bus.evict_tag;
                        dup_hit <= |evict_match;
                        if (|evict_match) begin
                            lru_update_q <= one_hot(lowest_idx(evict_match));
                        end
                        state <= I_CMP;
                    end
                end
                L_CMP: begin
                    resp_valid_q <= 1'b1;
                    if (|cmp_match) begin
                        resp_hit_q   <= 1'b1;
                        resp_way_q   <= lowest_idx(cmp_match);
                        lru_update_q <= one_hot(lowest_idx(cmp_match));
                        valid[lowest_idx(cmp_match)] <= 1'b0;
                    end
                    state <= L_RSP;
                end
                L_RSP: begin
                    state <= IDLE;
                end
                I_CMP: begin
                    if (dup_hit) begin
                        state <= IDLE;
                    end else begin
                        wr_en_q          <= 1'b1;
                        wr_way_q         <= victim_way;
                        tags[victim_way] <= req_tag;
                        valid[victim_way] <= 1'b1;
                        if (victim_free) begin
                            lru_update_q <= one_hot(victim_way);
                        end else begin
                            add_cache_q <= 1'b1;
                        end
                        state <= I_WR;
                    end
                end
                I_WR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.lookup_ready = (state == IDLE);
    assign bus.evict_ready  = (state == IDLE) && !bus.lookup_valid;
    assign bus.busy         = (state != IDLE);
    assign bus.lru_clr      = ~reset;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_hit     = resp_hit_q;
    assign bus.resp_way     = resp_way_q;
    assign bus.wr_en        = wr_en_q;
    assign bus.wr_way       = wr_way_q;
    assign bus.lru_update   = lru_update_q;
    assign bus.add_cache    = add_cache_q;

endmodule

// File: tb/tb_victim_cache_ctrl.sv
// Self-checking bench for victim_cache_ctrl: directed scenarios followed by random
// lookups/inserts, all predicted by a tag-to-way dictionary model of the cache.
module tb_victim_cache_ctrl;

    localparam int TAG_W = 26;

    logic clk;
    logic reset;
    int   assert_count;
    int   fail_count;

    victim_cache_ctrl_if #(.TAG_W(TAG_W)) bus ();

    victim_cache_ctrl #(.TAG_W(TAG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Model: which way each resident tag lives in, plus per-way occupancy.
    logic [2:0]       resident [logic [TAG_W-1:0]];
    logic [TAG_W-1:0] way_tag  [8];
    bit   [7:0]       way_used;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        resident.delete();
        way_used = '0;
        for (int i = 0; i < 8; i++) way_tag[i] = '0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
        end
    endtask

    // One complete lookup or insert, checked cycle by cycle against the model.
    task automatic applyStimulus(input bit is_lookup, input logic [TAG_W-1:0] t);
        logic        hit;
        logic [2:0]  way;
        logic        use_lru;
        int          found;
        logic [31:0] upd;
        hit = resident.exists(t);
        way = hit ? resident[t] : 3'd0;
        if (is_lookup) begin
            bus.lookup_valid = 1'b1;
            bus.lookup_tag   = t;
            #1;
            checkOutput("lookup_ready", 32'(bus.lookup_ready), 1);
            step();
            bus.lookup_valid = 1'b0;
            checkOutput("lcmp_busy", 32'(bus.busy), 1);
            checkOutput("lcmp_resp_valid", 32'(bus.resp_valid), 0);
            checkOutput("lcmp_lru_update", 32'(bus.lru_update), 0);
            step();
            upd = hit ? (32'd1 << way) : 32'd0;
            checkOutput("resp_valid", 32'(bus.resp_valid), 1);
            checkOutput("resp_hit", 32'(bus.resp_hit), 32'(hit));
            checkOutput("resp_way", 32'(bus.resp_way), 32'(way));
            checkOutput("lrsp_lru_update", 32'(bus.lru_update), upd);
            checkOutput("lrsp_wr_en", 32'(bus.wr_en), 0);
            checkOutput("lrsp_add_cache", 32'(bus.add_cache), 0);
            step();
            checkOutput("lookup_done_busy", 32'(bus.busy), 0);
            checkOutput("lookup_done_resp_valid", 32'(bus.resp_valid), 0);
            if (hit) begin
                resident.delete(t);
                way_used[way] = 1'b0;
            end
        end else begin
            use_lru = 1'b0;
            if (!hit) begin
                found = -1;
                for (int i = 0; i < 8; i++) if (!way_used[i] && found < 0) found = i;
                if (found >= 0) begin
                    way = 3'(found);
                end else begin
                    use_lru = 1'b1;
                    found = -1;
                    for (int i = 0; i < 8; i++) if (bus.lru_number[i] && found < 0) found = i;
                    way = (found >= 0) ? 3'(found) : 3'd0;
                end
            end
            bus.evict_valid = 1'b1;
            bus.evict_tag   = t;
            #1;
            checkOutput("evict_ready", 32'(bus.evict_ready), 1);
            step();
            bus.evict_valid = 1'b0;
            checkOutput("icmp_busy", 32'(bus.busy), 1);
            checkOutput("icmp_wr_en", 32'(bus.wr_en), 0);
            checkOutput("icmp_lru_update", 32'(bus.lru_update), hit ? (32'd1 << way) : 32'd0);
            step();
            if (hit) begin
                checkOutput("dup_done_busy", 32'(bus.busy), 0);
                checkOutput("dup_done_wr_en", 32'(bus.wr_en), 0);
                checkOutput("dup_done_lru_update", 32'(bus.lru_update), 0);
            end else begin
                checkOutput("iwr_wr_en", 32'(bus.wr_en), 1);
                checkOutput("iwr_wr_way", 32'(bus.wr_way), 32'(way));
                checkOutput("iwr_lru_update", 32'(bus.lru_update),
                            use_lru ? 32'd0 : (32'd1 << way));
                checkOutput("iwr_add_cache", 32'(bus.add_cache), 32'(use_lru));
                step();
                checkOutput("insert_done_busy", 32'(bus.busy), 0);
                checkOutput("insert_done_wr_en", 32'(bus.wr_en), 0);
                checkOutput("insert_done_add_cache", 32'(bus.add_cache), 0);
                if (way_used[way]) resident.delete(way_tag[way]);
                resident[t]   = way;
                way_tag[way]  = t;
                way_used[way] = 1'b1;
            end
        end
    endtask

    initial begin
        assert_count     = 0;
        fail_count       = 0;
        reset            = 1'b0;
        bus.lookup_valid = 1'b0;
        bus.lookup_tag   = '0;
        bus.evict_valid  = 1'b0;
        bus.evict_tag    = '0;
        bus.lru_number   = 8'h00;
        model_clear();

        // Reset state
        step();
        step();
        checkOutput("rst_busy", 32'(bus.busy), 0);
        checkOutput("rst_resp_valid", 32'(bus.resp_valid), 0);
        checkOutput("rst_wr_en", 32'(bus.wr_en), 0);
        checkOutput("rst_lru_update", 32'(bus.lru_update), 0);
        checkOutput("rst_add_cache", 32'(bus.add_cache), 0);
        checkOutput("rst_lru_clr", 32'(bus.lru_clr), 1);
        reset = 1'b1;
        #1;
        checkOutput("run_lru_clr", 32'(bus.lru_clr), 0);

        // Fill all eight ways in order
        $display("[TB] fill ways with 0x10..0x17");
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, TAG_W'(32'h10 + i));

        // Lookup hit frees the way, repeat misses
        $display("[TB] lookup 0x13 twice");
        applyStimulus(1'b1, TAG_W'(32'h13));
        applyStimulus(1'b1, TAG_W'(32'h13));

        // Insert refills the freed way
        applyStimulus(1'b0, TAG_W'(32'h20));

        // Full cache: replace the LRU-indicated way
        $display("[TB] replacement through lru_number");
        bus.lru_number = 8'h10;
        applyStimulus(1'b0, TAG_W'(32'h30));
        applyStimulus(1'b1, TAG_W'(32'h14));

        // Simultaneous lookup and evict: lookup first, evict held until IDLE
        $display("[TB] lookup/evict collision");
        bus.lookup_valid = 1'b1;
        bus.lookup_tag   = TAG_W'(32'h99);
        bus.evict_valid  = 1'b1;
        bus.evict_tag    = TAG_W'(32'h15);
        #1;
        checkOutput("coll_lookup_ready", 32'(bus.lookup_ready), 1);
        checkOutput("coll_evict_ready", 32'(bus.evict_ready), 0);
        step();
        bus.lookup_valid = 1'b0;
        checkOutput("coll_lcmp_evict_ready", 32'(bus.evict_ready), 0);
        checkOutput("coll_lcmp_busy", 32'(bus.busy), 1);
        step();
        checkOutput("coll_resp_valid", 32'(bus.resp_valid), 1);
        checkOutput("coll_resp_hit", 32'(bus.resp_hit), 0);
        checkOutput("coll_resp_way", 32'(bus.resp_way), 0);
        checkOutput("coll_lrsp_evict_ready", 32'(bus.evict_ready), 0);
        step();
        checkOutput("coll_idle_evict_ready", 32'(bus.evict_ready), 1);
        step();
        bus.evict_valid = 1'b0;
        checkOutput("coll_dup_lru_update", 32'(bus.lru_update),
                    resident.exists(TAG_W'(32'h15)) ? (32'd1 << resident[TAG_W'(32'h15)]) : 32'd0);
        checkOutput("coll_dup_wr_en", 32'(bus.wr_en), 0);
        step();
        checkOutput("coll_done_busy", 32'(bus.busy), 0);
        checkOutput("coll_done_wr_en", 32'(bus.wr_en), 0);

        // Reset asserted in the middle of a write
        $display("[TB] reset during I_WR");
        bus.lru_number  = 8'h04;
        bus.evict_valid = 1'b1;
        bus.evict_tag   = TAG_W'(32'h40);
        step();
        bus.evict_valid = 1'b0;
        step();
        checkOutput("midrst_wr_en_before", 32'(bus.wr_en), 1);
        reset = 1'b0;
        #1;
        checkOutput("midrst_wr_en", 32'(bus.wr_en), 0);
        checkOutput("midrst_busy", 32'(bus.busy), 0);
        checkOutput("midrst_lru_update", 32'(bus.lru_update), 0);
        checkOutput("midrst_add_cache", 32'(bus.add_cache), 0);
        checkOutput("midrst_lru_clr", 32'(bus.lru_clr), 1);
        model_clear();
        step();
        reset = 1'b1;
        #1;
        applyStimulus(1'b1, TAG_W'(32'h10));
        applyStimulus(1'b1, TAG_W'(32'h40));
        applyStimulus(1'b0, TAG_W'(32'h50));

        // Random traffic over a small tag pool so hits, duplicates and replacements recur
        $display("[TB] random traffic");
        for (int n = 0; n < 120; n++) begin
            if ($urandom_range(0, 7) == 0) bus.lru_number = 8'h00;
            else bus.lru_number = 8'($urandom_range(0, 255));
            applyStimulus(1'($urandom_range(0, 1)), TAG_W'(32'h100 + $urandom_range(0, 11)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
